line_endpoint_stager: RTL and testbench

- Sits directly upstream of line_sprite. Accepts endpoint pairs (A then B) from the tracking/detection logic over a valid/ready handshake.
- Clamps each point to the active screen, optionally smooths the pair against the previously shown line, and commits it only at the start of vertical blank. x1/x2/y1/y2 therefore stay frozen for the whole visible frame.
- Drives line_active, and drives a one-cycle sprite reset that re-seeds line_sprite's stepping state at every frame boundary.

---
 rtl/line_endpoint_stager.sv | 160 ++++++++++++++++
 tb/tb_line_endpoint_stager.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_endpoint_stager.sv
// Stages endpoint pairs for line_sprite: clamps, optionally IIR-smooths against the shown line,
// and commits only at the vertical-blank boundary so endpoints stay frozen across the visible frame.
module line_endpoint_stager #(
  parameter int unsigned H_ACTIVE       = 1280,
  parameter int unsigned V_ACTIVE       = 720,
  parameter int unsigned SMOOTH_SHIFT   = 2,
  parameter int unsigned TIMEOUT_FRAMES = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        pt_valid_in,
  output logic        pt_ready_out,
  input  logic [10:0] pt_x_in,
  input  logic [9:0]  pt_y_in,
  output logic [10:0] x1_out,
  output logic [9:0]  y1_out,
  output logic [10:0] x2_out,
  output logic [9:0]  y2_out,
  output logic        line_active_out,
  output logic        sprite_rst_out
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned DW = 12;
  localparam int unsigned MW = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] V_BND  = YW'(V_ACTIVE);
  localparam logic [MW-1:0] MISS_T = MW'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {WAIT_A, HAVE_A, PENDING} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   ax_q, ax_d, bx_q, bx_d, x1_q, x1_d, x2_q, x2_d;
  logic [YW-1:0]   ay_q, ay_d, by_q, by_d, y1_q, y1_d, y2_q, y2_d;
  logic            act_q, act_d, srst_q, srst_d;
  logic [MW-1:0]   miss_q, miss_d;

  logic            xfer;
  logic            boundary;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic [MW-1:0]   miss_inc;

  // Moves old toward new by (new-old) >>> SMOOTH_SHIFT; result always lies between them.
  function automatic logic [XW-1:0] smooth_x(input logic snap, input logic [XW-1:0] old_v,
                                             input logic [XW-1:0] new_v);
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] sum;
    if (snap || SMOOTH_SHIFT == 0) return new_v;
    diff = $signed({1'b0, new_v}) - $signed({1'b0, old_v});
    sum  = $signed({1'b0, old_v}) + (diff >>> SMOOTH_SHIFT);
    return sum[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] smooth_y(input logic snap, input logic [YW-1:0] old_v,
                                             input logic [YW-1:0] new_v);
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] sum;
    if (snap || SMOOTH_SHIFT == 0) return new_v;
    diff = $signed({2'b00, new_v}) - $signed({2'b00, old_v});
    sum  = $signed({2'b00, old_v}) + (diff >>> SMOOTH_SHIFT);
    return sum[YW-1:0];
  endfunction

  assign pt_ready_out = (state_q != PENDING);
  assign xfer         = pt_valid_in && pt_ready_out;
  assign boundary     = (vcount_in == V_BND) && (hcount_in == '0);
  assign cx           = (pt_x_in > X_MAX) ? X_MAX : pt_x_in;
  assign cy           = (pt_y_in > Y_MAX) ? Y_MAX : pt_y_in;

  always_comb begin
    state_d  = state_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    bx_d     = bx_q;
    by_d     = by_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    act_d    = act_q;
    srst_d   = 1'b0;
    miss_d   = miss_q;
    miss_inc = (miss_q == MISS_T) ? miss_q : miss_q + MW'(1);

    case (state_q)
      WAIT_A: if (xfer) begin
        ax_d    = cx;
        ay_d    = cy;
        state_d = HAVE_A;
      end
      HAVE_A: if (xfer) begin
        bx_d    = cx;
        by_d    = cy;
        state_d = PENDING;
      end
      default: ;
    endcase

    // Frame boundary: commit a complete pair, otherwise age the line toward timeout.
    if (boundary) begin
      srst_d = 1'b1;
      if (state_q == PENDING) begin
        x1_d    = smooth_x(!act_q, x1_q, ax_q);
        y1_d    = smooth_y(!act_q, y1_q, ay_q);
        x2_d    = smooth_x(!act_q, x2_q, bx_q);
        y2_d    = smooth_y(!act_q, y2_q, by_q);
        act_d   = 1'b1;
        miss_d  = '0;
        state_d = WAIT_A;
      end else begin
        miss_d = miss_inc;
        if (miss_inc == MISS_T) act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= WAIT_A;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      act_q   <= 1'b0;
      srst_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      act_q   <= act_d;
      srst_q  <= srst_d;
      miss_q  <= miss_d;
    end
  end

  assign x1_out          = x1_q;
  assign y1_out          = y1_q;
  assign x2_out          = x2_q;
  assign y2_out          = y2_q;
  assign line_active_out = act_q;
  assign sprite_rst_out  = srst_q;

endmodule

// File: tb/tb_line_endpoint_stager.sv
// Self-checking bench for line_endpoint_stager: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_line_endpoint_stager;

  localparam int SHIFT = 2;
  localparam int TF    = 3;
  localparam int HA    = 1280;
  localparam int VA    = 720;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        pt_valid_in = 1'b0;
  logic        pt_ready_out;
  logic [10:0] pt_x_in = '0;
  logic [9:0]  pt_y_in = '0;
  logic [10:0] x1_out, x2_out;
  logic [9:0]  y1_out, y2_out;
  logic        line_active_out, sprite_rst_out;

  line_endpoint_stager #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SMOOTH_SHIFT(SHIFT), .TIMEOUT_FRAMES(TF)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pt_valid_in(pt_valid_in), .pt_ready_out(pt_ready_out), .pt_x_in(pt_x_in),
    .pt_y_in(pt_y_in), .x1_out(x1_out), .y1_out(y1_out), .x2_out(x2_out),
    .y2_out(y2_out), .line_active_out(line_active_out), .sprite_rst_out(sprite_rst_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: staged points in a queue, committed line as plain integers.
  int mq_x[$];
  int mq_y[$];
  int m_x1, m_y1, m_x2, m_y2, m_miss;
  bit m_act, m_sr;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int smooth(input int o, input int n);
    int d;
    int den;
    if (!m_act || SHIFT == 0) return n;
    d   = n - o;
    den = 1 << SHIFT;
    if (d >= 0) return o + d / den;
    return o - ((-d + den - 1) / den);
  endfunction

  task automatic model_reset();
    mq_x.delete();
    mq_y.delete();
    m_x1 = 0; m_y1 = 0; m_x2 = 0; m_y2 = 0;
    m_act = 0; m_sr = 0; m_miss = 0;
  endtask

  task automatic model_edge(input bit v, input int x, input int y, input bit bnd);
    bit xfer;
    int nx1, ny1, nx2, ny2;
    xfer = v && (mq_x.size() < 2);
    m_sr = bnd;
    if (bnd) begin
      if (mq_x.size() == 2) begin
        nx1 = smooth(m_x1, mq_x[0]);
        ny1 = smooth(m_y1, mq_y[0]);
        nx2 = smooth(m_x2, mq_x[1]);
        ny2 = smooth(m_y2, mq_y[1]);
        m_x1 = nx1; m_y1 = ny1; m_x2 = nx2; m_y2 = ny2;
        m_act = 1; m_miss = 0;
        mq_x.delete();
        mq_y.delete();
      end else begin
        if (m_miss < TF) m_miss++;
        if (m_miss == TF) m_act = 0;
      end
    end
    if (xfer) begin
      mq_x.push_back(x > HA - 1 ? HA - 1 : x);
      mq_y.push_back(y > VA - 1 ? VA - 1 : y);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, " x1"}, int'(x1_out), m_x1);
    chk({tag, " y1"}, int'(y1_out), m_y1);
    chk({tag, " x2"}, int'(x2_out), m_x2);
    chk({tag, " y2"}, int'(y2_out), m_y2);
    chk({tag, " line_active"}, int'(line_active_out), int'(m_act));
    chk({tag, " sprite_rst"}, int'(sprite_rst_out), int'(m_sr));
  endtask

  // One clock: drive at negedge, check ready pre-edge, update model at posedge, check at next negedge.
  task automatic step(input bit v, input int x, input int y, input bit bnd, input string tag);
    pt_valid_in = v;
    pt_x_in     = 11'(x);
    pt_y_in     = 10'(y);
    if (bnd) begin
      vcount_in = 10'(VA);
      hcount_in = '0;
    end else if ($urandom_range(0, 1) == 1) begin
      vcount_in = 10'(VA);
      hcount_in = 11'($urandom_range(1, 2047));
    end else begin
      vcount_in = 10'($urandom_range(0, VA - 1));
      hcount_in = 11'($urandom_range(0, 2047));
    end
    #1;
    chk({tag, " ready"}, int'(pt_ready_out), int'(mq_x.size() < 2));
    @(posedge clk_in);
    model_edge(v, x, y, bnd);
    @(negedge clk_in);
    compare_model(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ready"}, int'(pt_ready_out), 1);
    chk({tag, " x1"}, int'(x1_out), 0);
    chk({tag, " y1"}, int'(y1_out), 0);
    chk({tag, " x2"}, int'(x2_out), 0);
    chk({tag, " y2"}, int'(y2_out), 0);
    chk({tag, " line_active"}, int'(line_active_out), 0);
    chk({tag, " sprite_rst"}, int'(sprite_rst_out), 0);
  endtask

  task automatic do_reset();
    pt_valid_in = 1'b1;
    pt_x_in     = 11'd100;
    pt_y_in     = 10'd50;
    rst_n_in    = 1'b0;
    #1;
    model_reset();
    check_zero("reset");
    @(negedge clk_in);
    @(negedge clk_in);
    check_zero("reset_hold");
    rst_n_in = 1'b1;
  endtask

  typedef struct {
    bit v; int x; int y; bit bnd;
    int ex1; int ey1; int ex2; int ey2; bit eact; bit esr;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1, 100,  50, 0,    0,   0,   0,   0, 0, 0};
    tbl[1]  = '{1, 300, 200, 0,    0,   0,   0,   0, 0, 0};
    tbl[2]  = '{0,   0,   0, 1,  100,  50, 300, 200, 1, 1};
    tbl[3]  = '{0,   0,   0, 0,  100,  50, 300, 200, 1, 0};
    tbl[4]  = '{1, 200,  50, 0,  100,  50, 300, 200, 1, 0};
    tbl[5]  = '{1, 201, 200, 0,  100,  50, 300, 200, 1, 0};
    tbl[6]  = '{0,   0,   0, 1,  125,  50, 275, 200, 1, 1};
    tbl[7]  = '{0,   0,   0, 0,  125,  50, 275, 200, 1, 0};
    tbl[8]  = '{0,   0,   0, 1,  125,  50, 275, 200, 1, 1};
    tbl[9]  = '{0,   0,   0, 0,  125,  50, 275, 200, 1, 0};
    tbl[10] = '{0,   0,   0, 1,  125,  50, 275, 200, 1, 1};
    tbl[11] = '{0,   0,   0, 1,  125,  50, 275, 200, 0, 1};
    tbl[12] = '{0,   0,   0, 0,  125,  50, 275, 200, 0, 0};
    tbl[13] = '{1, 2000, 900, 0, 125,  50, 275, 200, 0, 0};
    tbl[14] = '{1,   5,   5, 0,  125,  50, 275, 200, 0, 0};
    tbl[15] = '{0,   0,   0, 1, 1279, 719,   5,   5, 1, 1};
    tbl[16] = '{1,   7,   7, 1, 1279, 719,   5,   5, 1, 1};
    tbl[17] = '{1,   7,   7, 0, 1279, 719,   5,   5, 1, 0};
    tbl[18] = '{0,   0,   0, 1,  961, 541,   5,   5, 1, 1};

    #2;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      step(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].bnd, tag);
      chk({tag, " exp_x1"}, int'(x1_out), tbl[i].ex1);
      chk({tag, " exp_y1"}, int'(y1_out), tbl[i].ey1);
      chk({tag, " exp_x2"}, int'(x2_out), tbl[i].ex2);
      chk({tag, " exp_y2"}, int'(y2_out), tbl[i].ey2);
      chk({tag, " exp_active"}, int'(line_active_out), int'(tbl[i].eact));
      chk({tag, " exp_srst"}, int'(sprite_rst_out), int'(tbl[i].esr));
    end

    // B lands on the boundary: no commit; then async reset mid-PENDING discards the pair.
    step(1, 10, 10, 0, "bnd_a");
    step(1, 20, 20, 1, "bnd_b");
    chk("bnd_b held_x1", int'(x1_out), 961);
    chk("bnd_b pending", int'(pt_ready_out), 0);
    step(0, 0, 0, 0, "pend_idle");
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check_zero("mid_reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step(0, 0, 0, 1, "post_rst_bnd");
    chk("post_rst_bnd x2", int'(x2_out), 0);
    chk("post_rst_bnd active", int'(line_active_out), 0);
    chk("post_rst_bnd srst", int'(sprite_rst_out), 1);

    // Degenerate pair A==B commits as-is.
    step(1, 640, 360, 0, "deg_a");
    step(1, 640, 360, 0, "deg_b");
    step(0, 0, 0, 1, "deg_bnd");
    chk("deg x1", int'(x1_out), 640);
    chk("deg x2", int'(x2_out), 640);

    for (int i = 0; i < 600; i++) begin
      bit v, bnd;
      v   = ($urandom_range(0, 1) == 1);
      bnd = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n_in = 1'b0;
        #1;
        model_reset();
        check_zero("rand_reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
      end
      step(v, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), bnd, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
